// File: rtl/sop_truth_table_scanner_pkg.sv
// Shared types and widths for the SOP truth-table scanner.
package sop_scan_pkg;

   localparam int N_VARS   = 4;   // inputs a,b,c,d of the function under test
   localparam int TT_W     = 16;  // one truth-table bit per minterm
   localparam int CNT_W    = 5;   // ones count 0..16
   localparam int SETTLE_W = 4;   // settle counter, SETTLE_CYCLES up to 15

   typedef enum logic [1:0] {
      IDLE,
      DRIVE,
      SAMPLE,
      DONE
   } state_t;

endpackage

// File: rtl/sop_truth_table_scanner_if.sv
// Control/result bundle between the lab top level, the scanner and the SOP datapath.
// Optional self-check signals are present only with SOP_SCAN_CHECK_EN defined.
interface sop_scan_if;
   import sop_scan_pkg::*;

   logic              start;
   logic              abort;
   logic              busy;
   logic              done;
   logic [N_VARS-1:0] eval_vec;
   logic              eval_x;
   logic [TT_W-1:0]   truth_table;
   logic [CNT_W-1:0]  ones_count;
`ifdef SOP_SCAN_CHECK_EN
   logic [TT_W-1:0]   expected_tt;
   logic              mismatch;

   modport slave  (input  start, abort, eval_x, expected_tt,
                   output busy, done, eval_vec, truth_table, ones_count, mismatch);
   modport master (output start, abort, eval_x, expected_tt,
                   input  busy, done, eval_vec, truth_table, ones_count, mismatch);
`else
   modport slave  (input  start, abort, eval_x,
                   output busy, done, eval_vec, truth_table, ones_count);
   modport master (output start, abort, eval_x,
                   input  busy, done, eval_vec, truth_table, ones_count);
`endif

endinterface

// File: rtl/sop_truth_table_scanner_capture.sv
// sop_tt_capture: truth-table register and ones-count accumulator.
// clr wipes both for a new scan; we writes bit_in at position idx and adds it to the count.
module sop_tt_capture
   import sop_scan_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              we,
   input  logic [N_VARS-1:0] idx,
   input  logic              bit_in,
   output logic [TT_W-1:0]   truth_table,
   output logic [CNT_W-1:0]  ones_count
);

   // Capture one minterm result per write; count saturates naturally at 16 of 16.
   // NOTE: reset is sampled on the clock edge (synchronous), so rst_n sits inside the edge-triggered branch.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         // NOTE: non-blocking assignments keep every register updating from pre-edge values.
         truth_table <= '0;
         ones_count  <= '0;
      end else if (clr) begin
         truth_table <= '0;
         ones_count  <= '0;
      end else if (we) begin
         truth_table[idx] <= bit_in;
         ones_count       <= ones_count + CNT_W'(bit_in);
      end
   end

endmodule

// File: rtl/sop_truth_table_scanner.sv
// sop_truth_table_scanner: walks a 4-input SOP datapath through all 16 minterms,
// holding each vector SETTLE_CYCLES cycles before sampling eval_x.
// Optional feature macro: SOP_SCAN_CHECK_EN (compare result with expected_tt).
module sop_truth_table_scanner
   import sop_scan_pkg::*;
#(
   parameter int SETTLE_CYCLES = 1
)(
   input logic     clk,
   input logic     rst_n,
   sop_scan_if.slave bus
);

   localparam logic [SETTLE_W-1:0] SETTLE_LD = SETTLE_W'(SETTLE_CYCLES);

   state_t              state, state_nx;
   logic [N_VARS-1:0]   idx, idx_nx;
   logic [SETTLE_W-1:0] cnt, cnt_nx;
   logic                tt_we, tt_clr;
   logic [TT_W-1:0]     truth_table;
   logic [CNT_W-1:0]    ones_count;

   // State, minterm index and settle counter registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         idx   <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         idx   <= idx_nx;
         cnt   <= cnt_nx;
      end
   end

   // Next-state logic; abort beats start and beats the final write.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path infers a latch.
      state_nx = state;
      idx_nx   = idx;
      cnt_nx   = cnt;
      tt_we    = 1'b0;
      tt_clr   = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.start && !bus.abort) begin
               state_nx = DRIVE;
               idx_nx   = '0;
               cnt_nx   = SETTLE_LD;
               tt_clr   = 1'b1;
            end
         end
         DRIVE: begin
            if (bus.abort) begin
               state_nx = IDLE;
            end else begin
               cnt_nx = cnt - SETTLE_W'(1);
               if (cnt == SETTLE_W'(1)) state_nx = SAMPLE;
            end
         end
         SAMPLE: begin
            if (bus.abort) begin
               state_nx = IDLE;
            end else begin
               tt_we = 1'b1;
               if (idx == N_VARS'(TT_W - 1)) begin
                  state_nx = DONE;
               end else begin
                  idx_nx   = idx + N_VARS'(1);
                  cnt_nx   = SETTLE_LD;
                  state_nx = DRIVE;
               end
            end
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   sop_tt_capture u_capture (
      .clk         (clk),
      .rst_n       (rst_n),
      .clr         (tt_clr),
      .we          (tt_we),
      .idx         (idx),
      .bit_in      (bus.eval_x),
      .truth_table (truth_table),
      .ones_count  (ones_count)
   );

   assign bus.eval_vec    = idx;
   assign bus.busy        = (state == DRIVE) || (state == SAMPLE);
   assign bus.done        = (state == DONE);
   assign bus.truth_table = truth_table;
   assign bus.ones_count  = ones_count;

`ifdef SOP_SCAN_CHECK_EN
   logic [TT_W-1:0] exp_q;
   logic            mm_q;

   // Latch expected table on accepted start; record the verdict when the scan completes.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         exp_q <= '0;
         mm_q  <= 1'b0;
      end else if (tt_clr) begin
         exp_q <= bus.expected_tt;
         mm_q  <= 1'b0;
      end else if (state == DONE) begin
         mm_q  <= (truth_table != exp_q);
      end
   end

   // Verdict is visible during the done pulse itself, then held.
   assign bus.mismatch = (state == DONE) ? (truth_table != exp_q) : mm_q;
`endif

endmodule
